countdown_sequencer: RTL and testbench

- Synchronous controller that sequences a down counter as a programmable countdown timer: load, run, pause, abort, done pulse and optional auto-reload.
- Replaces the ripple-clocked down counter for any use needing a single clock domain and a defined terminal event.
- Sits between control logic (start/pause/stop strobes) and consumers of the count value and done pulse.

---
 rtl/countdown_pkg.sv | 14 +
 rtl/countdown_sequencer_if.sv | 30 +++
 rtl/down_counter_sync.sv | 31 +++
 rtl/countdown_sequencer.sv | 137 +++++++++++++
 tb/tb_countdown_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared constants and state encoding for the countdown sequencer.
package countdown_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned PRE_W_DEF = 4;

    // 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control strobes and status bundle between a controller and the countdown sequencer.
interface countdown_sequencer_if
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
);

    logic             start;
    logic             pause;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, pause, stop, auto_reload, load_val, prescale,
        input  count, busy, done, state
    );

    modport slave (
        input  start, pause, stop, auto_reload, load_val, prescale,
        output count, busy, done, state
    );

endinterface

// File: rtl/down_counter_sync.sv
// Synchronous loadable down counter that saturates at zero.
module down_counter_sync
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             is_one
);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (en && (q != '0)) begin
            q <= q - WIDTH'(1);
        end
    end

    assign is_one = (q == WIDTH'(1));

endmodule

// File: rtl/countdown_sequencer.sv
// Programmable countdown timer: load, prescaled run, pause, abort, done pulse, optional auto-reload.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input logic                  Clk,
    input logic                  Clr,
    countdown_sequencer_if.slave bus
);

    state_t           state_r;
    logic [PRE_W-1:0] presc_cnt;
    logic [PRE_W-1:0] presc_term;
    logic [WIDTH-1:0] reload_r;
    logic             reload_en;
    logic             done_r;

    logic [WIDTH-1:0] q;
    logic             is_one;
    logic             tick;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_clear;
    logic [WIDTH-1:0] cnt_data;

    // Counter control decoded from the same priority order the FSM uses.
    always_comb begin
        tick      = (presc_cnt == presc_term);
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_clear = 1'b0;
        cnt_data  = reload_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    cnt_load = 1'b1;
                    cnt_data = bus.load_val;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    cnt_clear = 1'b1;
                end else if (!bus.pause && tick) begin
                    if (is_one && reload_en) begin
                        cnt_load = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            PAUSE: begin
                cnt_clear = bus.stop;
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
    end

    down_counter_sync #(.WIDTH(WIDTH)) u_counter (
        .Clk       (Clk),
        .Clr       (Clr),
        .load      (cnt_load),
        .load_data (cnt_data),
        .en        (cnt_en),
        .clear     (cnt_clear),
        .q         (q),
        .is_one    (is_one)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_r    <= IDLE;
            presc_cnt  <= '0;
            presc_term <= '0;
            reload_r   <= '0;
            reload_en  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        reload_r   <= bus.load_val;
                        presc_term <= bus.prescale;
                        reload_en  <= bus.auto_reload;
                        presc_cnt  <= '0;
                        // A zero load expires immediately without leaving IDLE.
                        if (bus.load_val != '0) begin
                            state_r <= RUN;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_r   <= IDLE;
                        presc_cnt <= '0;
                    end else if (bus.pause) begin
                        state_r <= PAUSE;
                    end else if (!tick) begin
                        presc_cnt <= presc_cnt + PRE_W'(1);
                    end else begin
                        presc_cnt <= '0;
                        if (is_one) begin
                            done_r <= 1'b1;
                            if (!reload_en) begin
                                state_r <= IDLE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        state_r   <= IDLE;
                        presc_cnt <= '0;
                    end else if (!bus.pause) begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    presc_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.count = q;
    assign bus.busy  = (state_r == RUN) || (state_r == PAUSE);
    assign bus.done  = done_r;
    assign bus.state = state_r;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed self-checking bench for countdown_sequencer.
module tb_countdown_sequencer;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    logic Clk;
    logic Clr;
    int   n_cmp;
    int   n_err;

    countdown_sequencer_if #(.WIDTH(4), .PRE_W(4)) bus ();

    countdown_sequencer #(.WIDTH(4), .PRE_W(4)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] cnt, input logic [1:0] st,
                              input logic bsy, input logic dn);
        check_eq({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check_eq({tag, ".state"}, 32'(bus.state), 32'(st));
        check_eq({tag, ".busy"},  32'(bus.busy),  32'(bsy));
        check_eq({tag, ".done"},  32'(bus.done),  32'(dn));
    endtask

    // Expected count/done after each edge of a load=2, P=2, auto-reload run.
    logic [3:0] rl_cnt  [12];
    logic       rl_done [12];

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        rl_cnt  = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd2};
        rl_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        Clr             = 1'b1;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;
        bus.load_val    = 4'd0;
        bus.prescale    = 4'd0;
        step();
        step();
        expect_out("reset", 4'd0, S_IDLE, 1'b0, 1'b0);
        Clr = 1'b0;

        // Basic countdown from 3 with no prescale.
        bus.load_val = 4'd3;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        expect_out("basic.e0", 4'd3, S_RUN, 1'b1, 1'b0);
        step();
        expect_out("basic.e1", 4'd2, S_RUN, 1'b1, 1'b0);
        step();
        expect_out("basic.e2", 4'd1, S_RUN, 1'b1, 1'b0);
        step();
        expect_out("basic.e3", 4'd0, S_IDLE, 1'b0, 1'b1);
        step();
        expect_out("basic.e4", 4'd0, S_IDLE, 1'b0, 1'b0);

        // Load 5; a start in RUN must be ignored; pause at count 3.
        bus.load_val = 4'd5;
        bus.start    = 1'b1;
        step();
        expect_out("pz.e0", 4'd5, S_RUN, 1'b1, 1'b0);
        bus.load_val = 4'd9;
        step();
        bus.start = 1'b0;
        expect_out("pz.restart_ignored", 4'd4, S_RUN, 1'b1, 1'b0);
        step();
        expect_out("pz.c3", 4'd3, S_RUN, 1'b1, 1'b0);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("pz.held", 4'd3, S_PAUSE, 1'b1, 1'b0);
        end
        bus.pause = 1'b0;
        step();
        expect_out("pz.resume", 4'd3, S_RUN, 1'b1, 1'b0);
        step();
        expect_out("pz.c2", 4'd2, S_RUN, 1'b1, 1'b0);
        step();
        expect_out("pz.c1", 4'd1, S_RUN, 1'b1, 1'b0);
        step();
        expect_out("pz.done", 4'd0, S_IDLE, 1'b0, 1'b1);

        // Second run aborted at count 2.
        bus.load_val = 4'd5;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        expect_out("stop.c2", 4'd2, S_RUN, 1'b1, 1'b0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        expect_out("stop.abort", 4'd0, S_IDLE, 1'b0, 1'b0);
        step();
        expect_out("stop.after", 4'd0, S_IDLE, 1'b0, 1'b0);

        // Stop coincident with the terminal tick suppresses done.
        bus.load_val = 4'd2;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        expect_out("stopfin.c1", 4'd1, S_RUN, 1'b1, 1'b0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        expect_out("stopfin.abort", 4'd0, S_IDLE, 1'b0, 1'b0);
        step();
        check_eq("stopfin.nodone", 32'(bus.done), 32'd0);

        // Zero load expires at once and stays in IDLE.
        bus.load_val = 4'd0;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        expect_out("zero.e0", 4'd0, S_IDLE, 1'b0, 1'b1);
        step();
        expect_out("zero.e1", 4'd0, S_IDLE, 1'b0, 1'b0);

        // Prescaled auto-reload: count steps every 3 clocks, done every 6.
        bus.load_val    = 4'd2;
        bus.prescale    = 4'd2;
        bus.auto_reload = 1'b1;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
        bus.auto_reload = 1'b0;
        expect_out("reload.e0", 4'd2, S_RUN, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            expect_out($sformatf("reload.e%0d", i + 1), rl_cnt[i], S_RUN, 1'b1, rl_done[i]);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        expect_out("reload.abort", 4'd0, S_IDLE, 1'b0, 1'b0);

        // Maximum period: 15 * 16 = 240 clocks to done.
        bus.load_val = 4'hF;
        bus.prescale = 4'hF;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (bus.done) begin
                n = i;
                break;
            end
        end
        check_eq("maxper.edges", 32'(n), 32'd240);
        expect_out("maxper.end", 4'd0, S_IDLE, 1'b0, 1'b1);

        // Reset in the middle of a run, with start still asserted.
        bus.load_val = 4'd9;
        bus.prescale = 4'd0;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        expect_out("rstmid.before", 4'd6, S_RUN, 1'b1, 1'b0);
        Clr       = 1'b1;
        bus.start = 1'b1;
        step();
        expect_out("rstmid.after", 4'd0, S_IDLE, 1'b0, 1'b0);
        Clr       = 1'b0;
        bus.start = 1'b0;
        step();
        expect_out("rstmid.hold", 4'd0, S_IDLE, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
